// File: rtl/mult_pkg.sv
// mult_pkg: shared definitions for the multiplier-sharing controller.
//   - state_t   : controller FSM state encoding
//   - DEF_WIDTH : default operand width
//   - DEF_TIMEOUT : default RUN-cycle budget before the core is declared hung
package mult_pkg;

  localparam int DEF_WIDTH   = 6;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_RESP = 2'd3
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req    : request vector, one bit per requester
//   rr_ptr : index of the highest-priority requester this round
//   gnt    : one-hot pick (first set req bit at or above rr_ptr, wrapping)
//   found  : high when any request bit is set
module rr_pick #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   rr_ptr,
  output logic [NREQ-1:0] gnt,
  output logic            found
);

  int idx;

  // Walk offsets 0..NREQ-1 from the pointer; the first set bit wins.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!found && (i == idx) && req[i]) begin
          gnt[i] = 1'b1;
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl: shares one multi-cycle multiplier core among NREQ requesters.
//   clk, rst_n          : clock, synchronous active-low reset
//   req, a_in, b_in     : per-requester request level and packed operands
//   gnt                 : one-hot grant, held LOAD..RESP
//   rsp_valid           : one-hot single-cycle response strobe
//   rsp_product/rsp_err : result (0 with err=1 on core timeout), held until next RESP
//   busy                : controller not idle
//   mul_a/mul_b/mul_start, mul_done/mul_product : core handshake (start is a level)
module mult_share_ctrl
  import mult_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   a_in,
  input  logic [NREQ*WIDTH-1:0]   b_in,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         rsp_valid,
  output logic [2*WIDTH-1:0]      rsp_product,
  output logic                    rsp_err,
  output logic                    busy,
  output logic [WIDTH-1:0]        mul_a,
  output logic [WIDTH-1:0]        mul_b,
  output logic                    mul_start,
  input  logic                    mul_done,
  input  logic [2*WIDTH-1:0]      mul_product
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 5;

  state_t               state_q, state_d;
  logic [NREQ-1:0]      gnt_q, gnt_d;
  logic [NREQ-1:0]      rsp_valid_q, rsp_valid_d;
  logic [2*WIDTH-1:0]   rsp_product_q, rsp_product_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 busy_q, busy_d;
  logic                 mul_start_q, mul_start_d;
  logic [WIDTH-1:0]     mul_a_q, mul_a_d;
  logic [WIDTH-1:0]     mul_b_q, mul_b_d;
  logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]        gidx_q, gidx_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [NREQ-1:0]      pick_gnt;
  logic                 pick_found;
  logic [WIDTH-1:0]     a_slice [NREQ];
  logic [WIDTH-1:0]     b_slice [NREQ];
  logic [WIDTH-1:0]     sel_a, sel_b;
  logic [PW-1:0]        sel_idx;
  logic [PW-1:0]        next_ptr;
  logic [CW-1:0]        cnt_inc;

  rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .gnt    (pick_gnt),
    .found  (pick_found)
  );

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign a_slice[gi] = a_in[gi*WIDTH +: WIDTH];
    assign b_slice[gi] = b_in[gi*WIDTH +: WIDTH];
  end

  // One-hot pick drives an AND-OR mux; also recovers the binary index.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) begin
        sel_a   = sel_a | a_slice[i];
        sel_b   = sel_b | b_slice[i];
        sel_idx = PW'(i);
      end
    end
  end

  assign next_ptr = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
  assign cnt_inc  = cnt_q + CW'(1);

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    rsp_valid_d   = '0;
    rsp_product_d = rsp_product_q;
    rsp_err_d     = rsp_err_q;
    mul_start_d   = mul_start_q;
    mul_a_d       = mul_a_q;
    mul_b_d       = mul_b_q;
    rr_ptr_d      = rr_ptr_q;
    gidx_d        = gidx_q;
    cnt_d         = cnt_q;
    case (state_q)
      ST_IDLE: begin
        mul_start_d = 1'b0;
        if (pick_found) begin
          gnt_d   = pick_gnt;
          gidx_d  = sel_idx;
          mul_a_d = sel_a;
          mul_b_d = sel_b;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        // start is still low this cycle; it rises together with entry to RUN
        cnt_d       = '0;
        mul_start_d = 1'b1;
        state_d     = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_inc;
        // done is checked first so it wins over a coincident timeout
        if (mul_done) begin
          rsp_product_d = mul_product;
          rsp_err_d     = 1'b0;
          rsp_valid_d   = gnt_q;
          mul_start_d   = 1'b0;
          state_d       = ST_RESP;
        end else if (cnt_inc == CW'(TIMEOUT)) begin
          rsp_product_d = '0;
          rsp_err_d     = 1'b1;
          rsp_valid_d   = gnt_q;
          mul_start_d   = 1'b0;
          state_d       = ST_RESP;
        end
      end
      ST_RESP: begin
        gnt_d    = '0;
        rr_ptr_d = next_ptr;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      gnt_q         <= '0;
      rsp_valid_q   <= '0;
      rsp_product_q <= '0;
      rsp_err_q     <= 1'b0;
      busy_q        <= 1'b0;
      mul_start_q   <= 1'b0;
      mul_a_q       <= '0;
      mul_b_q       <= '0;
      rr_ptr_q      <= '0;
      gidx_q        <= '0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_product_q <= rsp_product_d;
      rsp_err_q     <= rsp_err_d;
      busy_q        <= busy_d;
      mul_start_q   <= mul_start_d;
      mul_a_q       <= mul_a_d;
      mul_b_q       <= mul_b_d;
      rr_ptr_q      <= rr_ptr_d;
      gidx_q        <= gidx_d;
      cnt_q         <= cnt_d;
    end
  end

  assign gnt         = gnt_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_product = rsp_product_q;
  assign rsp_err     = rsp_err_q;
  assign busy        = busy_q;
  assign mul_a       = mul_a_q;
  assign mul_b       = mul_b_q;
  assign mul_start   = mul_start_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// tb_mult_share_ctrl: scoreboard bench for mult_share_ctrl with a behavioural
// signed multiplier core (optionally hung to force timeouts).
module tb_mult_share_ctrl;

  localparam int NREQ  = 2;
  localparam int WIDTH = 6;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [NREQ-1:0]       req = '0;
  logic [NREQ*WIDTH-1:0] a_in = '0;
  logic [NREQ*WIDTH-1:0] b_in = '0;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       rsp_valid;
  logic [2*WIDTH-1:0]    rsp_product;
  logic                  rsp_err;
  logic                  busy;
  logic [WIDTH-1:0]      mul_a;
  logic [WIDTH-1:0]      mul_b;
  logic                  mul_start;
  logic                  mul_done = 1'b0;
  logic [2*WIDTH-1:0]    mul_product = '0;

  mult_share_ctrl #(.NREQ(NREQ), .WIDTH(WIDTH), .TIMEOUT(15)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_product(rsp_product),
    .rsp_err(rsp_err), .busy(busy), .mul_a(mul_a), .mul_b(mul_b),
    .mul_start(mul_start), .mul_done(mul_done), .mul_product(mul_product)
  );

  always #5 clk = ~clk;

  // Core stand-in: clears while start=0, finishes 5 cycles into a run.
  logic [3:0] core_cnt = '0;
  logic       core_hang = 1'b0;
  always @(posedge clk) begin
    if (!mul_start) begin
      core_cnt <= '0;
      mul_done <= 1'b0;
    end else if (!mul_done && !core_hang) begin
      if (core_cnt == 4'd4) begin
        mul_done    <= 1'b1;
        mul_product <= 12'($signed({{6{mul_a[5]}}, mul_a}) * $signed({{6{mul_b[5]}}, mul_b}));
      end else begin
        core_cnt <= core_cnt + 4'd1;
      end
    end
  end

  typedef struct {
    int         idx;
    logic [11:0] prod;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   resp_count = 0;
  int   run_cycles = 0;
  int   last_run = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req_v);
    total++;
    if (act !== req_v) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req_v);
    end
  endtask

  // Monitor: pops one expectation per response strobe.
  always @(negedge clk) begin
    if (!rst_n) begin
      run_cycles = 0;
    end else if (rsp_valid != '0) begin
      last_run   = run_cycles;
      run_cycles = 0;
      $display("rsp valid=%b prod=%h err=%b", rsp_valid, rsp_product, rsp_err);
      if (exp_q.size() == 0) begin
        check("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(1 << e.idx));
        check("rsp_product", 32'(rsp_product), 32'(e.prod));
        check("rsp_err", 32'(rsp_err), 32'(e.err));
      end
      resp_count++;
    end else if (mul_start) begin
      run_cycles++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input int idx, input logic [11:0] prod, input logic err);
    exp_t e;
    e.idx = idx; e.prod = prod; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic wait_resp(input int target);
    int guard;
    guard = 0;
    while (resp_count < target && guard < 100) begin
      tick();
      guard++;
    end
    if (resp_count < target) check("wait_resp_timeout", 32'(resp_count), 32'(target));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, 32'(gnt), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_product"}, 32'(rsp_product), 32'd0);
    check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_mul_a"}, 32'(mul_a), 32'd0);
    check({tag, "_mul_b"}, 32'(mul_b), 32'd0);
    check({tag, "_mul_start"}, 32'(mul_start), 32'd0);
  endtask

  initial begin
    tick(); tick(); tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Single request from r0: 3*5
    a_in[5:0] = 6'd3; b_in[5:0] = 6'd5;
    push(0, 12'h00F, 1'b0);
    req = 2'b01;
    tick();
    check("load_gnt", 32'(gnt), 32'h1);
    check("load_mul_start", 32'(mul_start), 32'h0);
    check("load_busy", 32'(busy), 32'h1);
    check("load_mul_a", 32'(mul_a), 32'd3);
    check("load_mul_b", 32'(mul_b), 32'd5);
    tick();
    check("run_mul_start", 32'(mul_start), 32'h1);
    wait_resp(1);
    req = 2'b00;

    // Signed operands from r1: -3*5
    a_in[11:6] = 6'h3D; b_in[11:6] = 6'd5;
    push(1, 12'hFF1, 1'b0);
    req = 2'b10;
    wait_resp(2);
    req = 2'b00;

    // Contention: rotation must start at r0 and alternate
    a_in = {6'd4, 6'd2}; b_in = {6'd4, 6'd3};
    push(0, 12'h006, 1'b0); push(1, 12'h010, 1'b0);
    push(0, 12'h006, 1'b0); push(1, 12'h010, 1'b0);
    req = 2'b11;
    wait_resp(6);
    req = 2'b00;

    // Timeout with a hung core
    core_hang = 1'b1;
    push(0, 12'h000, 1'b1);
    req = 2'b01;
    wait_resp(7);
    req = 2'b00;
    check("timeout_run_cycles", 32'(last_run), 32'd15);
    check("timeout_idle_busy", 32'(busy), 32'd0);
    check("timeout_gnt_clear", 32'(gnt), 32'd0);

    // Reset mid-RUN: rr_ptr=1 so r1 is granted, then aborted
    a_in = {6'd7, 6'd5}; b_in = {6'd2, 6'd6};
    req = 2'b11;
    tick();
    check("pre_reset_gnt", 32'(gnt), 32'h2);
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    check_all_zero("midrun_reset");
    rst_n = 1'b1;
    core_hang = 1'b0;
    push(0, 12'h01E, 1'b0); push(1, 12'h00E, 1'b0);
    tick();
    check("regrant_gnt", 32'(gnt), 32'h1);
    wait_resp(9);
    req = 2'b00;

    // Operand change after grant is ignored
    a_in[5:0] = 6'd3; b_in[5:0] = 6'd5;
    push(0, 12'h00F, 1'b0);
    req = 2'b01;
    tick(); tick(); tick();
    a_in[5:0] = 6'd7;
    tick();
    check("held_mul_a", 32'(mul_a), 32'd3);
    wait_resp(10);
    req = 2'b00;

    tick(); tick(); tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("resp_total", 32'(resp_count), 32'd10);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
